// File: rtl/fpaddsub_align_module.sv
// Two-stage FP add/sub operand alignment: order operands by magnitude, then right-shift the smaller mantissa.
// Optional sticky collection controlled by the FPADDSUB_ALIGN_STICKY_EN macro.
module fpaddsub_align_module (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Operation,
    input  logic        InValid,
    output logic        InReady,
    output logic [25:0] Mmax,
    output logic [25:0] Mmin,
    output logic        Sticky,
    output logic [7:0]  Exp,
    output logic [4:0]  Shift,
    output logic        Sign,
    output logic        OpEff,
    output logic        OutValid,
    input  logic        OutReady
);
    logic        w_en1, w_en2;
    logic [7:0]  w_exp_a, w_exp_b, w_exp_max, w_exp_min, w_d;
    logic [25:0] w_man_a, w_man_b;
    logic        w_swap, w_sb, w_opeff;
    logic [4:0]  w_shift;

    logic        r_v1, r_sign1, r_opeff1;
    logic [25:0] r_mmax1, r_mmin1;
    logic [7:0]  r_exp1;
    logic [4:0]  r_shift1;

    logic        r_v2, r_sign2, r_opeff2;
    logic [25:0] r_mmax2, r_mmin2;
    logic [7:0]  r_exp2;
    logic [4:0]  r_shift2;

    assign w_en2   = !r_v2 | OutReady;
    assign w_en1   = !r_v1 | w_en2;
    assign InReady = w_en1;

    // Denormals use effective exponent 1 with a cleared hidden bit.
    assign w_exp_a = (A[30:23] == 8'd0) ? 8'd1 : A[30:23];
    assign w_exp_b = (B[30:23] == 8'd0) ? 8'd1 : B[30:23];
    assign w_man_a = {|A[30:23], A[22:0], 2'b00};
    assign w_man_b = {|B[30:23], B[22:0], 2'b00};

    assign w_swap    = {w_exp_b, B[22:0]} > {w_exp_a, A[22:0]};
    assign w_exp_max = w_swap ? w_exp_b : w_exp_a;
    assign w_exp_min = w_swap ? w_exp_a : w_exp_b;
    assign w_d       = w_exp_max - w_exp_min;
    assign w_shift   = (w_d >= 8'd26) ? 5'd26 : w_d[4:0];
    assign w_sb      = B[31] ^ Operation;
    assign w_opeff   = A[31] ^ w_sb;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v1     <= 1'b0;
            r_mmax1  <= '0;
            r_mmin1  <= '0;
            r_exp1   <= '0;
            r_shift1 <= '0;
            r_sign1  <= 1'b0;
            r_opeff1 <= 1'b0;
        end else if (w_en1) begin
            r_v1     <= InValid;
            r_mmax1  <= w_swap ? w_man_b : w_man_a;
            r_mmin1  <= w_swap ? w_man_a : w_man_b;
            r_exp1   <= w_exp_max;
            r_shift1 <= w_shift;
            r_sign1  <= w_swap ? w_sb : A[31];
            r_opeff1 <= w_opeff;
        end
    end

    // Logarithmic shifter: level gi shifts by 16>>gi under control of r_shift1[4-gi].
    logic [25:0] w_stage [0:5];
    assign w_stage[0] = r_mmin1;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_lvl
            localparam int SH = 16 >> gi;
            assign w_stage[gi+1] = r_shift1[4-gi] ? (w_stage[gi] >> SH) : w_stage[gi];
        end
    endgenerate

`ifdef FPADDSUB_ALIGN_STICKY_EN
    logic w_stk [0:5];
    logic r_sticky2;
    assign w_stk[0] = 1'b0;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_stk
            localparam int SH = 16 >> gi;
            assign w_stk[gi+1] = w_stk[gi] | (r_shift1[4-gi] & (|w_stage[gi][SH-1:0]));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_sticky2 <= 1'b0;
        else if (w_en2)
            r_sticky2 <= w_stk[5];
    end
    assign Sticky = r_sticky2;
`else
    assign Sticky = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v2     <= 1'b0;
            r_mmax2  <= '0;
            r_mmin2  <= '0;
            r_exp2   <= '0;
            r_shift2 <= '0;
            r_sign2  <= 1'b0;
            r_opeff2 <= 1'b0;
        end else if (w_en2) begin
            r_v2     <= r_v1;
            r_mmax2  <= r_mmax1;
            r_mmin2  <= w_stage[5];
            r_exp2   <= r_exp1;
            r_shift2 <= r_shift1;
            r_sign2  <= r_sign1;
            r_opeff2 <= r_opeff1;
        end
    end

    assign OutValid = r_v2;
    assign Mmax     = r_mmax2;
    assign Mmin     = r_mmin2;
    assign Exp      = r_exp2;
    assign Shift    = r_shift2;
    assign Sign     = r_sign2;
    assign OpEff    = r_opeff2;

endmodule
